// File: rtl/piso_shift_register_param.sv
// Parameterised parallel-in/serial-out shift register with a load handshake,
// per-frame length, selectable bit order, shift enable and gapless back-to-back frames.
module piso_shift_register_param #(
    parameter int   WIDTH      = 32,
    parameter logic FILL_BIT   = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0,
    localparam int  LEN_W      = $clog2(WIDTH + 1)
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Load_Valid_In,
    output logic             Load_Ready_Out,
    input  logic [WIDTH-1:0] Parallel_Data_In,
    input  logic [LEN_W-1:0] Length_In,
    input  logic             Msb_First_In,
    input  logic             Shift_En_In,
    output logic             Serial_Data_Out,
    output logic             Serial_Valid_Out,
    output logic             Busy_Out,
    output logic             Frame_Done_Out,
    output logic [WIDTH-1:0] Shift_Register_Out
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [LEN_W-1:0] count_r;
    logic             msb_first_r;
    logic             frame_done_r;

    logic             in_shift_s;
    logic             last_bit_s;
    logic             ready_s;
    logic             load_s;
    logic [LEN_W-1:0] eff_len_s;

    // A zero or oversized length request means a full-width frame.
    function automatic logic [LEN_W-1:0] effective_length(input logic [LEN_W-1:0] len);
        if ((len == {LEN_W{1'b0}}) || (len > LEN_W'(WIDTH))) begin
            return LEN_W'(WIDTH);
        end else begin
            return len;
        end
    endfunction

    assign in_shift_s = (state_r == ST_SHIFT);
    assign last_bit_s = in_shift_s && (count_r == LEN_W'(1)) && Shift_En_In;
    // Accepting a word on the last-bit cycle is what makes frames gapless.
    assign ready_s    = (!in_shift_s) || last_bit_s;
    assign load_s     = Load_Valid_In && ready_s;
    assign eff_len_s  = effective_length(Length_In);

    // Frame state machine: load, shift, count down and flag frame completion.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_r      <= ST_IDLE;
            shift_r      <= {WIDTH{1'b0}};
            count_r      <= {LEN_W{1'b0}};
            msb_first_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= last_bit_s;
            if (load_s) begin
                shift_r     <= Parallel_Data_In;
                count_r     <= eff_len_s;
                msb_first_r <= Msb_First_In;
                state_r     <= ST_SHIFT;
            end else if (in_shift_s && Shift_En_In) begin
                if (msb_first_r) begin
                    shift_r <= {shift_r[WIDTH-2:0], FILL_BIT};
                end else begin
                    shift_r <= {FILL_BIT, shift_r[WIDTH-1:1]};
                end
                count_r <= count_r - LEN_W'(1);
                if (count_r == LEN_W'(1)) begin
                    state_r <= ST_IDLE;
                end else begin
                    state_r <= ST_SHIFT;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign Load_Ready_Out     = ready_s;
    assign Serial_Data_Out    = in_shift_s ? (msb_first_r ? shift_r[WIDTH-1] : shift_r[0]) : IDLE_LEVEL;
    assign Serial_Valid_Out   = in_shift_s;
    assign Busy_Out           = in_shift_s;
    assign Frame_Done_Out     = frame_done_r;
    assign Shift_Register_Out = shift_r;

endmodule

// File: tb/tb_piso_shift_register_param.sv
// Bench for piso_shift_register_param: an 8-bit and a 32-bit instance share stimulus and
// are checked every cycle against a frame-queue model plus literal end-of-test expectations.
module tb_piso_shift_register_param;

    logic        clk;
    logic        rst;
    logic        lv;
    logic [31:0] data;
    logic [5:0]  len;
    logic        msb;
    logic        en;

    logic       rdy8, sd8, sv8, busy8, done8;
    logic [7:0] sr8;
    logic        rdy32, sd32, sv32, busy32, done32;
    logic [31:0] sr32;

    piso_shift_register_param #(.WIDTH(8), .FILL_BIT(1'b0), .IDLE_LEVEL(1'b0)) u8 (
        .Clk_In(clk), .Reset_In(rst), .Load_Valid_In(lv), .Load_Ready_Out(rdy8),
        .Parallel_Data_In(data[7:0]), .Length_In(len[3:0]), .Msb_First_In(msb),
        .Shift_En_In(en), .Serial_Data_Out(sd8), .Serial_Valid_Out(sv8), .Busy_Out(busy8),
        .Frame_Done_Out(done8), .Shift_Register_Out(sr8)
    );

    piso_shift_register_param #(.WIDTH(32), .FILL_BIT(1'b1), .IDLE_LEVEL(1'b1)) u32 (
        .Clk_In(clk), .Reset_In(rst), .Load_Valid_In(lv), .Load_Ready_Out(rdy32),
        .Parallel_Data_In(data), .Length_In(len), .Msb_First_In(msb),
        .Shift_En_In(en), .Serial_Data_Out(sd32), .Serial_Valid_Out(sv32), .Busy_Out(busy32),
        .Frame_Done_Out(done32), .Shift_Register_Out(sr32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Model: per instance, the list of frame bits still to be sent, in emission order.
    bit fb   [2][32];
    int rem  [2];
    int pos  [2];
    bit edone[2];

    // Captures of what the DUTs actually emitted.
    logic [15:0] cap8;
    logic [31:0] cap32;
    int n8, n32, vcnt8, bcnt8, dcnt8, dcnt32;
    logic [7:0] sr8_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input logic rdy, input logic sd, input logic sv,
                              input logic busy, input logic done);
        logic e_rdy, e_sd, e_sv, e_done, idle;
        string p;
        p    = (i == 0) ? "u8" : "u32";
        idle = (i == 0) ? 1'b0 : 1'b1;
        if (rst) begin
            e_rdy = 1'b1; e_sv = 1'b0; e_sd = idle; e_done = 1'b0;
        end else begin
            e_sv   = (rem[i] > 0);
            e_sd   = (rem[i] > 0) ? fb[i][pos[i]] : idle;
            e_rdy  = (rem[i] == 0) || ((rem[i] == 1) && en);
            e_done = edone[i];
        end
        chk({p, "_ready"}, {31'd0, rdy},  {31'd0, e_rdy});
        chk({p, "_sdata"}, {31'd0, sd},   {31'd0, e_sd});
        chk({p, "_valid"}, {31'd0, sv},   {31'd0, e_sv});
        chk({p, "_busy"},  {31'd0, busy}, {31'd0, e_sv});
        chk({p, "_done"},  {31'd0, done}, {31'd0, e_done});
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  w, l, eff;
            bit  rdy;
            if (rst) begin
                rem[i]   = 0;
                pos[i]   = 0;
                edone[i] = 1'b0;
            end else begin
                rdy      = (rem[i] == 0) || ((rem[i] == 1) && en);
                edone[i] = (rem[i] == 1) && en;
                if ((rem[i] > 0) && en) begin
                    pos[i]++;
                    rem[i]--;
                end
                if (lv && rdy) begin
                    w   = (i == 0) ? 8 : 32;
                    l   = (i == 0) ? int'(len[3:0]) : int'(len);
                    eff = ((l == 0) || (l > w)) ? w : l;
                    for (int k = 0; k < eff; k++) begin
                        fb[i][k] = msb ? data[w-1-k] : data[k];
                    end
                    pos[i] = 0;
                    rem[i] = eff;
                end
            end
        end
    endtask

    // One clock cycle: check and capture at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        check_inst(0, rdy8, sd8, sv8, busy8, done8);
        check_inst(1, rdy32, sd32, sv32, busy32, done32);
        if (!rst) begin
            if (sv8 && en)  begin cap8 = {cap8[14:0], sd8}; n8++; end
            if (sv32 && en) begin cap32 = {sd32, cap32[31:1]}; n32++; end
            if (sv8)   vcnt8++;
            if (busy8) bcnt8++;
            if (done8) begin dcnt8++; sr8_done = sr8; end
            if (done32) dcnt32++;
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        cap8 = 16'd0; cap32 = 32'd0;
        n8 = 0; n32 = 0; vcnt8 = 0; bcnt8 = 0; dcnt8 = 0; dcnt32 = 0;
        sr8_done = 8'd0;
    endtask

    task automatic load(input logic [31:0] d, input logic [5:0] l, input logic m);
        lv = 1'b1; data = d; len = l; msb = m;
        tick();
        lv = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while ((busy8 || busy32) && (c < maxc)) begin
            tick();
            c++;
        end
        chk("idle_timeout", {30'd0, busy8, busy32}, 32'd0);
        tick();
    endtask

    initial begin
        int k, acc;
        logic a;
        total = 0; bad = 0;
        rst = 1'b1; lv = 1'b0; data = 32'd0; len = 6'd0; msb = 1'b0; en = 1'b0;
        for (int i = 0; i < 2; i++) begin rem[i] = 0; pos[i] = 0; edone[i] = 1'b0; end
        clr();
        tick(); tick();
        chk("reset_sr8",  {24'd0, sr8}, 32'd0);
        chk("reset_sr32", sr32, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: full-width LSB-first frame on the 32-bit instance
        clr(); en = 1'b1;
        load(32'hA5A5_0F0F, 6'd0, 1'b0);
        wait_idle(60);
        chk("t1_bits32", cap32, 32'hA5A5_0F0F);
        chk("t1_n32", n32, 32);
        chk("t1_done32", dcnt32, 1);

        // 2: 5-bit MSB-first frame
        clr();
        load(32'h0000_00B2, 6'd5, 1'b1);
        wait_idle(60);
        chk("t2_bits8", {27'd0, cap8[4:0]}, {27'd0, 5'b10110});
        chk("t2_n8", n8, 5);
        chk("t2_busy_cycles", bcnt8, 5);
        chk("t2_sr_at_done", {24'd0, sr8_done}, 32'h40);
        chk("t2_done8", dcnt8, 1);

        // 3: enable pulsed every 4th cycle
        clr(); en = 1'b0;
        load(32'h0000_0001, 6'd0, 1'b0);
        k = 0;
        while (busy8 && (k < 64)) begin
            en = ((k % 4) == 3);
            tick();
            k++;
        end
        en = 1'b1;
        chk("t3_bits8", {24'd0, cap8[7:0]}, 32'h80);
        chk("t3_n8", n8, 8);
        chk("t3_valid_cycles", vcnt8, 32);
        wait_idle(200);

        // 4: back-to-back frames with the load held high
        clr(); en = 1'b1;
        lv = 1'b1; data = 32'h0000_000F; len = 6'd0; msb = 1'b0;
        acc = 0; k = 0;
        while ((acc < 2) && (k < 40)) begin
            a = rdy8;
            tick();
            k++;
            if (a) begin
                acc++;
                if (acc == 1) data = 32'h0000_00F0;
                else lv = 1'b0;
            end
        end
        lv = 1'b0;
        wait_idle(60);
        chk("t4_bits8", {16'd0, cap8}, 32'hF00F);
        chk("t4_n8", n8, 16);
        chk("t4_valid_cycles", vcnt8, 16);
        chk("t4_done8", dcnt8, 2);

        // 5: reset in the middle of a frame, then a normal frame
        clr();
        load(32'h0000_00FF, 6'd0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("t5_busy8",  {31'd0, busy8}, 32'd0);
        chk("t5_valid8", {31'd0, sv8}, 32'd0);
        chk("t5_sd8",    {31'd0, sd8}, 32'd0);
        chk("t5_sr8",    {24'd0, sr8}, 32'd0);
        chk("t5_sd32",   {31'd0, sd32}, 32'd1);
        chk("t5_sr32",   sr32, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t5_no_done8",  dcnt8, 0);
        chk("t5_no_done32", dcnt32, 0);
        clr();
        load(32'h0000_003A, 6'd0, 1'b0);
        wait_idle(60);
        chk("t5_bits8", {24'd0, cap8[7:0]}, 32'h5C);
        chk("t5_n8", n8, 8);
        chk("t5_done8", dcnt8, 1);

        // 6: oversized length and a load attempt while not ready
        clr();
        load(32'h0000_00C5, 6'd12, 1'b0);
        tick(); tick();
        lv = 1'b1; data = 32'hFFFF_FFFF; len = 6'd3; msb = 1'b1;
        tick(); tick(); tick();
        lv = 1'b0;
        wait_idle(60);
        chk("t6_bits8", {24'd0, cap8[7:0]}, 32'hA3);
        chk("t6_n8", n8, 8);
        chk("t6_done8", dcnt8, 1);
        chk("t6_bits32", {20'd0, cap32[31:20]}, 32'h0C5);
        chk("t6_n32", n32, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
